// File: rtl/pc_sequencer_pkg.sv
// Shared types for the fetch-stage next-PC controller.
// Holds the sequencer state encoding and the PC register hold-control codes.
// No logic lives here; import with pc_sequencer_pkg::*.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } seq_state_t;

  localparam logic [1:0] PC_NOP_UPDATE = 2'b00;
  localparam logic [1:0] PC_NOP_STALL  = 2'b01;
  localparam logic [1:0] PC_NOP_HALT   = 2'b10;

  // Width of the redirect shadow counter; covers flush lengths up to 3.
  localparam int CNT_W = 2;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Latency: count reflects an increment one clock after inc.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment on request unless already saturated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks sequential/branch/jump address, drives PC hold and flushes.
// Latency: combinational; redirect target appears on pc_next in the request cycle.
// Backpressure: stall_req/halt hold the PC via pc_nop. Optional perf counters: PC_SEQUENCER_PERF_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_current,
  input  logic              stall_req,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc_next,
  output logic [1:0]        pc_nop,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [1:0]        seq_state
`ifdef PC_SEQUENCER_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_redirect_cnt
`endif
);

  localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam bit                MULTI_FLUSH = (FLUSH_CYCLES > 1);

  seq_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  redir_target;
  logic               redir_req;
  logic               take_redirect;

  // Jump outranks branch when both resolve in the same cycle.
  assign pc_inc       = pc_current + PC_ONE;
  assign redir_req    = jump | branch_taken;
  assign redir_target = jump ? jump_target : branch_target;
  assign seq_state    = state;

  // Next-state and output decode; reset overrides outputs so nothing leaks while held.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pc_next       = pc_inc;
    pc_nop        = PC_NOP_UPDATE;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    take_redirect = 1'b0;

    case (state)
      RUN: begin
        if (halt) begin
          pc_nop    = PC_NOP_HALT;
          pc_next   = pc_current;
          state_nxt = HALTED;
        end else if (redir_req) begin
          take_redirect = 1'b1;
        end else if (stall_req) begin
          pc_nop    = PC_NOP_STALL;
          pc_next   = pc_current;
          state_nxt = STALL;
        end
      end
      STALL: begin
        // A redirect squashes the stalled instruction, so it wins over the stall.
        if (redir_req) begin
          take_redirect = 1'b1;
        end else if (stall_req) begin
          pc_nop  = PC_NOP_STALL;
          pc_next = pc_current;
        end else begin
          state_nxt = RUN;
        end
      end
      REDIRECT: begin
        // Requests here come from squashed instructions and are dropped.
        flush_if_id = 1'b1;
        if (cnt <= CNT_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HALTED: begin
        if (!resume) begin
          pc_nop  = PC_NOP_HALT;
          pc_next = pc_current;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    if (take_redirect) begin
      pc_next     = redir_target;
      pc_nop      = PC_NOP_UPDATE;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      if (MULTI_FLUSH) begin
        cnt_nxt   = FLUSH_LOAD;
        state_nxt = REDIRECT;
      end else begin
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
    end

    if (reset) begin
      pc_next     = RESET_VECTOR;
      pc_nop      = PC_NOP_UPDATE;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
    end
  end

  // State and redirect shadow counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef PC_SEQUENCER_PERF_EN
  // flush_id_ex pulses exactly once per accepted redirect, so it doubles as the event.
  sat_counter #(.W(16)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_nop == PC_NOP_STALL),
    .count (perf_stall_cnt)
  );

  sat_counter #(.W(16)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_id_ex),
    .count (perf_redirect_cnt)
  );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver pushes expected outputs from a behavioural model,
// a negedge monitor pops and compares them against the DUT.
module tb_pc_sequencer;

  localparam int          FLUSH = 2;
  localparam logic [15:0] RV    = 16'h0000;

  logic        clk;
  logic        reset;
  logic [15:0] pc_current;
  logic        stall_req, branch_taken, jump, halt, resume;
  logic [15:0] branch_target, jump_target;
  logic [15:0] pc_next;
  logic [1:0]  pc_nop;
  logic        flush_if_id, flush_id_ex;
  logic [1:0]  seq_state;
`ifdef PC_SEQUENCER_PERF_EN
  logic [15:0] perf_stall_cnt, perf_redirect_cnt;
`endif

  pc_sequencer #(.ADDR_W(16), .RESET_VECTOR(RV), .FLUSH_CYCLES(FLUSH)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_current    (pc_current),
    .stall_req     (stall_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt          (halt),
    .resume        (resume),
    .pc_next       (pc_next),
    .pc_nop        (pc_nop),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .seq_state     (seq_state)
`ifdef PC_SEQUENCER_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc_next;
    logic [1:0]  nop;
    logic        fi;
    logic        fe;
    logic [1:0]  st;
    logic [15:0] ps;
    logic [15:0] pr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: mode flags, remaining flush shadow, modelled PC register.
  bit          m_halted  = 0;
  bit          m_stalled = 0;
  int          m_shadow  = 0;
  logic [15:0] pc_model  = 16'h0000;
  logic [15:0] m_stall_cnt = 0;
  logic [15:0] m_redir_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict outputs, then advance past the next rising edge.
  task automatic step(input bit r, input bit j, input logic [15:0] jt, input bit b,
                      input logic [15:0] bt, input bit s, input bit h, input bit rs);
    exp_t e;
    bit   accepted;
    reset = r; jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
    stall_req = s; halt = h; resume = rs; pc_current = pc_model;
    e.ps = m_stall_cnt;
    e.pr = m_redir_cnt;
    e.fi = 0; e.fe = 0; e.nop = 2'b00; e.st = 2'd0;
    accepted = 0;
    if (r) begin
      e.pc_next = RV;
      e.ps = 0; e.pr = 0;
      m_halted = 0; m_stalled = 0; m_shadow = 0;
      m_stall_cnt = 0; m_redir_cnt = 0;
    end else begin
      e.pc_next = pc_model + 16'd1;
      if (m_shadow > 0) begin
        e.st = 2'd2; e.fi = 1; m_shadow--;
      end else if (m_halted) begin
        e.st = 2'd3;
        if (rs) m_halted = 0;
        else begin e.nop = 2'b10; e.pc_next = pc_model; end
      end else begin
        e.st = m_stalled ? 2'd1 : 2'd0;
        if (h && !m_stalled) begin
          e.nop = 2'b10; e.pc_next = pc_model; m_halted = 1;
        end else if (j || b) begin
          e.pc_next = j ? jt : bt; e.fi = 1; e.fe = 1;
          m_shadow = FLUSH - 1; m_stalled = 0; accepted = 1;
        end else if (s) begin
          e.nop = 2'b01; e.pc_next = pc_model; m_stalled = 1;
        end else begin
          m_stalled = 0;
        end
      end
      if (e.nop == 2'b01 && m_stall_cnt != 16'hFFFF) m_stall_cnt++;
      if (accepted && m_redir_cnt != 16'hFFFF) m_redir_cnt++;
      if (e.nop == 2'b00) pc_model = e.pc_next;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 16'h0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle, compare mid-cycle against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_next",     32'(pc_next),     32'(e.pc_next));
      chk("pc_nop",      32'(pc_nop),      32'(e.nop));
      chk("flush_if_id", 32'(flush_if_id), 32'(e.fi));
      chk("flush_id_ex", 32'(flush_id_ex), 32'(e.fe));
      chk("seq_state",   32'(seq_state),   32'(e.st));
`ifdef PC_SEQUENCER_PERF_EN
      chk("perf_stall_cnt",    32'(perf_stall_cnt),    32'(e.ps));
      chk("perf_redirect_cnt", 32'(perf_redirect_cnt), 32'(e.pr));
`endif
    end
  end

  initial begin
    reset = 1; pc_current = 0; stall_req = 0; branch_taken = 0; jump = 0;
    halt = 0; resume = 0; branch_target = 0; jump_target = 0;

    // Reset, then sequential fetch from 0.
    pc_model = 16'h0000;
    step(1, 0, 16'h0, 0, 16'h0, 0, 0, 0);
    step(1, 1, 16'h1234, 0, 16'h0, 1, 1, 1);
    idle(4);

    // Wrap at the top of the address space.
    pc_model = 16'hFFFF;
    idle(1);

    // Taken branch; a second branch inside the flush shadow is dropped.
    pc_model = 16'h0008;
    step(0, 0, 16'h0, 1, 16'h0040, 0, 0, 0);
    step(0, 0, 16'h0, 1, 16'h0999, 0, 0, 0);
    idle(2);

    // Three-cycle stall at 0x0010.
    pc_model = 16'h0010;
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 16'h0, 1, 0, 0);
    idle(1);

    // Jump overrides a stall, both entering from RUN and from STALL.
    step(0, 1, 16'h0100, 0, 16'h0, 1, 0, 0);
    idle(2);
    step(0, 0, 16'h0, 0, 16'h0, 1, 0, 0);
    step(0, 1, 16'h0200, 1, 16'h0300, 1, 1, 0);
    idle(2);

    // Halt, wait, resume.
    pc_model = 16'h0020;
    step(0, 0, 16'h0, 0, 16'h0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 16'h0777, 1, 16'h0888, 1, 0, 0);
    step(0, 0, 16'h0, 0, 16'h0, 0, 0, 1);
    idle(1);

    // Reset while halted, and while in the redirect shadow.
    pc_model = 16'h0020;
    step(0, 0, 16'h0, 0, 16'h0, 0, 1, 0);
    idle(2);
    step(1, 0, 16'h0, 0, 16'h0, 0, 0, 0);
    idle(1);
    step(0, 1, 16'h0500, 0, 16'h0, 0, 0, 0);
    step(1, 0, 16'h0, 0, 16'h0, 0, 0, 0);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, j, b, s, h, rs;
      if ($urandom_range(0, 31) == 0) pc_model = 16'($urandom);
      r  = ($urandom_range(0, 199) == 0);
      j  = ($urandom_range(0, 15) == 0);
      b  = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 5) == 0);
      h  = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 3) == 0);
      step(r, j, 16'($urandom), b, 16'($urandom), s, h, rs);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the fetch stage. It takes the current PC from the PC register and chooses the next address: sequential, branch or jump target. It drives the register's 2-bit nop hold control and issues pipeline flush strobes. A small FSM handles load-use stalls, multi-cycle redirect flushes and a halt/resume state.

## Interface
Parameters:
- ADDR_W, 16, PC width.
- RESET_VECTOR, 16'h0000, address driven on pc_next while in reset.
- FLUSH_CYCLES, 2, number of cycles flush_if_id is asserted per redirect. Legal range 1..3.

Ports:
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-high.
- pc_current, in, ADDR_W, PC register output.
- stall_req, in, 1, load-use stall from the hazard unit.
- branch_taken, in, 1, resolved taken branch.
- branch_target, in, ADDR_W, branch target address.
- jump, in, 1, unconditional jump.
- jump_target, in, ADDR_W, jump target address.
- halt, in, 1, halt instruction decoded.
- resume, in, 1, external restart request.
- pc_next, out, ADDR_W, drives the PC register input.
- pc_nop, out, 2, PC register hold control. Encodings: 00 update, 01 stall hold, 10 halt hold.
- flush_if_id, out, 1, squash the IF/ID stage.
- flush_id_ex, out, 1, squash the ID/EX stage.
- seq_state, out, 2, current FSM state (debug).

## Operation
- The FSM state is registered. All outputs are combinational from the state, the redirect counter and the inputs.
- States: RUN=0, STALL=1, REDIRECT=2, HALTED=3.
- Sequential next address is pc_current+1, modulo 2^ADDR_W; 16'hFFFF wraps to 16'h0000.

RUN, with input priority halt > jump > branch_taken > stall_req > sequential:
- halt: pc_nop=10, pc_next=pc_current, go to HALTED.
- jump:
  - pc_next=jump_target, pc_nop=00.
  - flush_if_id=1 and flush_id_ex=1 this cycle.
  - If FLUSH_CYCLES>1, load cnt=FLUSH_CYCLES-1 and go to REDIRECT; otherwise stay in RUN.
- branch_taken: same as jump, using branch_target.
- stall_req: pc_nop=01, pc_next=pc_current, go to STALL.
- none of the above: pc_next=pc_current+1, pc_nop=00.

STALL:
- pc_nop=01 while stall_req stays high.
- A jump or branch_taken arriving in STALL overrides the stall: handle it exactly as in RUN. The stalled instruction is flushed.
- When stall_req drops: sequential update and return to RUN.
- halt is ignored in STALL.

REDIRECT:
- flush_if_id=1, flush_id_ex=0.
- pc_next=pc_current+1, pc_nop=00.
- halt, jump, branch_taken and stall_req are all ignored, because they come from squashed instructions.
- cnt decrements each cycle; when cnt==1, return to RUN.

HALTED:
- pc_nop=10, pc_next=pc_current, no flushes.
- resume=1: sequential update and go to RUN.
- All other inputs are ignored.

## Timing
- Redirect latency: the target appears on pc_next in the same cycle as branch_taken or jump. The PC register holds the target after the next rising edge.
- Flush profile for one redirect:
  - flush_if_id is high for exactly FLUSH_CYCLES consecutive cycles.
  - flush_id_ex is high for only the first of those cycles.
- A redirect in STALL on cycle N produces pc_nop=00 on cycle N.
- Reset behaviour:
  - Assertion immediately forces state=RUN and cnt=0.
  - While reset is high: pc_next=RESET_VECTOR, pc_nop=00, flush_if_id=0, flush_id_ex=0, seq_state=0.
  - Reset in the middle of REDIRECT or HALTED abandons that state with no residual flush.
- Simultaneous jump and branch_taken: jump wins.
- resume asserted outside HALTED has no effect.

## Configuration
- Macro: PC_SEQUENCER_PERF_EN.
- When defined, two outputs are added:
  - perf_stall_cnt (16 bits): cycles spent with pc_nop==01.
  - perf_redirect_cnt (16 bits): accepted redirects.
- Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

## Structure
- Package pc_sequencer_pkg holds:
  - the seq_state_t enum (RUN, STALL, REDIRECT, HALTED);
  - the nop encodings PC_NOP_UPDATE=2'b00, PC_NOP_STALL=2'b01, PC_NOP_HALT=2'b10.
- Sub-module sat_counter (16-bit saturating counter with increment enable) is instantiated twice, only under PC_SEQUENCER_PERF_EN.

## Test plan
- Reset, then idle inputs for 4 cycles starting at pc_current=0x0000 -> pc_next=0x0001, 0x0002, 0x0003, 0x0004; pc_nop=00 throughout.
- pc_current=0xFFFF with no requests -> pc_next=0x0000.
- branch_taken with target 0x0040 at FLUSH_CYCLES=2 -> pc_next=0x0040 the same cycle; flush_if_id high for 2 cycles; flush_id_ex high for 1 cycle; a branch_taken during the second cycle is ignored.
- stall_req held for 3 cycles at PC 0x0010 -> pc_nop=01 for 3 cycles, then pc_next=0x0011; with PERF_EN, perf_stall_cnt=3.
- stall_req together with jump to 0x0100 -> pc_next=0x0100, pc_nop=00, state becomes REDIRECT.
- halt at PC 0x0020, wait 5 cycles, assert resume -> pc_nop=10 for 5 cycles, then pc_next=0x0021. Repeat with reset asserted during HALTED -> state RUN, pc_next=RESET_VECTOR.
